// File: rtl/vdma_burst_scheduler_pkg.sv
// Shared definitions for the VDMA burst scheduler: scheduler state encoding,
// channel direction constants and the beat-size helper.
package vdma_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARB,
        ST_ISSUE,
        ST_WAIT_DONE
    } sched_state_t;

    localparam logic DIR_WR = 1'b0;
    localparam logic DIR_RD = 1'b1;

    // Bytes moved per AXI beat for a given data-bus width in bits.
    function automatic int unsigned beat_bytes(input int unsigned dsize);
        return dsize / 8;
    endfunction

endpackage

// File: rtl/vdma_burst_scheduler_chan_tracker.sv
// Per-channel frame position tracker for the VDMA burst scheduler.
// Keeps the current line index, beats remaining in the line and the line
// start address, and derives the next burst length and byte address.
//
// Ports:
//   clock, rst_n              clock / async active-low reset
//   load                      restart at line 0 of the frame (uses cfg inputs)
//   advance                   the burst of n beats has completed
//   frame_base, line_stride   byte address of line 0 / distance between lines
//   line_beats, vactive       beats per line / lines per frame
//   n                         beats in the next burst, min(BURST_LEN, beats_left)
//   addr                      byte address of the next burst
//   line_start                next burst begins a line
//   line_end                  next burst finishes the line
//   frame_wrap                next burst finishes the last line of the frame
module vdma_chan_tracker
    import vdma_sched_pkg::*;
#(
    parameter int unsigned AXI_DSIZE = 512,
    parameter int unsigned ASIZE     = 32,
    parameter int unsigned BURST_LEN = 32
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             load,
    input  logic             advance,
    input  logic [ASIZE-1:0] frame_base,
    input  logic [ASIZE-1:0] line_stride,
    input  logic [15:0]      line_beats,
    input  logic [15:0]      vactive,
    output logic [8:0]       n,
    output logic [ASIZE-1:0] addr,
    output logic             line_start,
    output logic             line_end,
    output logic             frame_wrap
);

    localparam int unsigned BEAT_BYTES = beat_bytes(AXI_DSIZE);
    localparam logic [15:0] BURST_MAX  = 16'(BURST_LEN);

    logic [15:0]      line_idx;
    logic [15:0]      beats_left;
    logic [15:0]      beats_done;
    logic [ASIZE-1:0] line_addr;
    logic             last_line;

    assign n          = (beats_left > BURST_MAX) ? 9'(BURST_LEN) : beats_left[8:0];
    assign beats_done = line_beats - beats_left;
    assign addr       = line_addr + ASIZE'(beats_done) * ASIZE'(BEAT_BYTES);
    assign line_start = (beats_left == line_beats);
    assign line_end   = (beats_left <= BURST_MAX);
    assign last_line  = (line_idx == vactive - 16'd1);
    assign frame_wrap = line_end && last_line;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            line_idx   <= '0;
            beats_left <= '0;
            line_addr  <= '0;
        end else if (load) begin
            line_idx   <= '0;
            beats_left <= line_beats;
            line_addr  <= frame_base;
        end else if (advance) begin
            if (line_end) begin
                beats_left <= line_beats;
                if (last_line) begin
                    line_idx  <= '0;
                    line_addr <= frame_base;
                end else begin
                    line_idx  <= line_idx + 16'd1;
                    line_addr <= line_addr + line_stride;
                end
            end else begin
                beats_left <= beats_left - 16'(n);
            end
        end
    end

endmodule

// File: rtl/vdma_burst_scheduler.sv
// VDMA burst scheduler: shares one AXI burst-command port between the write
// channel (drains the write stream FIFO into memory) and the read channel
// (fills the read stream FIFO from memory) over a single-frame buffer.
//
// Ports:
//   clock, rst_n                  clock / async active-low reset
//   enable                        run request; config latched on its rising edge
//   frame_base, line_stride       frame geometry in bytes
//   line_beats, vactive           beats per line / lines per frame
//   wr_data_count, rd_space       write FIFO fill / read FIFO free space
//   cmd_valid, cmd_ready          burst command handshake
//   cmd_dir, cmd_addr, cmd_len    command payload (0 = write, len = beats-1)
//   cmd_done                      completion pulse of the outstanding burst
//   busy                          scheduler not idle
//   lines_stored                  lines written but not yet read back
//   wr_frame_done, rd_frame_done  one-cycle pulses when a channel wraps
//   cfg_err                       latched configuration was invalid
module vdma_burst_scheduler
    import vdma_sched_pkg::*;
#(
    parameter int unsigned AXI_DSIZE = 512,
    parameter int unsigned ASIZE     = 32,
    parameter int unsigned BURST_LEN = 32,
    parameter int unsigned CSIZE     = 10
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [ASIZE-1:0] frame_base,
    input  logic [ASIZE-1:0] line_stride,
    input  logic [15:0]      line_beats,
    input  logic [15:0]      vactive,
    input  logic [CSIZE-1:0] wr_data_count,
    input  logic [CSIZE-1:0] rd_space,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic             cmd_dir,
    output logic [ASIZE-1:0] cmd_addr,
    output logic [7:0]       cmd_len,
    input  logic             cmd_done,
    output logic             busy,
    output logic [15:0]      lines_stored,
    output logic             wr_frame_done,
    output logic             rd_frame_done,
    output logic             cfg_err
);

    sched_state_t state, next_state;

    logic             enable_q;
    logic             latch;
    logic             cfg_ok;
    logic             last_grant;
    logic [ASIZE-1:0] cfg_base, cfg_stride;
    logic [15:0]      cfg_beats, cfg_vactive;
    logic [ASIZE-1:0] eff_base, eff_stride;
    logic [15:0]      eff_beats, eff_vactive;

    logic [8:0]       wr_n, rd_n, sel_n;
    logic [ASIZE-1:0] wr_addr, rd_addr, sel_addr;
    logic             wr_line_start, wr_line_end, wr_frame_wrap;
    logic             rd_line_start, rd_line_end, rd_frame_wrap;
    logic             wr_adv, rd_adv, done_evt;
    logic             wr_elig, rd_elig, any_elig, grant_dir;

    assign latch  = (state == ST_IDLE) && enable && !enable_q;
    assign cfg_ok = (line_beats != '0) && (vactive != '0);

    // The trackers reload in the latch cycle, before the config registers
    // hold the new values, so they see the live inputs at that moment.
    assign eff_base    = latch ? frame_base  : cfg_base;
    assign eff_stride  = latch ? line_stride : cfg_stride;
    assign eff_beats   = latch ? line_beats  : cfg_beats;
    assign eff_vactive = latch ? vactive     : cfg_vactive;

    assign done_evt = (state == ST_WAIT_DONE) && cmd_done;
    assign wr_adv   = done_evt && (cmd_dir == DIR_WR);
    assign rd_adv   = done_evt && (cmd_dir == DIR_RD);

    vdma_chan_tracker #(
        .AXI_DSIZE (AXI_DSIZE),
        .ASIZE     (ASIZE),
        .BURST_LEN (BURST_LEN)
    ) u_wr_trk (
        .clock       (clock),
        .rst_n       (rst_n),
        .load        (latch),
        .advance     (wr_adv),
        .frame_base  (eff_base),
        .line_stride (eff_stride),
        .line_beats  (eff_beats),
        .vactive     (eff_vactive),
        .n           (wr_n),
        .addr        (wr_addr),
        .line_start  (wr_line_start),
        .line_end    (wr_line_end),
        .frame_wrap  (wr_frame_wrap)
    );

    vdma_chan_tracker #(
        .AXI_DSIZE (AXI_DSIZE),
        .ASIZE     (ASIZE),
        .BURST_LEN (BURST_LEN)
    ) u_rd_trk (
        .clock       (clock),
        .rst_n       (rst_n),
        .load        (latch),
        .advance     (rd_adv),
        .frame_base  (eff_base),
        .line_stride (eff_stride),
        .line_beats  (eff_beats),
        .vactive     (eff_vactive),
        .n           (rd_n),
        .addr        (rd_addr),
        .line_start  (rd_line_start),
        .line_end    (rd_line_end),
        .frame_wrap  (rd_frame_wrap)
    );

    // Occupancy only gates a channel when it is about to open a new line.
    always_comb begin
        wr_elig  = (32'(wr_data_count) >= 32'(wr_n)) &&
                   (!wr_line_start || (lines_stored < cfg_vactive));
        rd_elig  = (32'(rd_space) >= 32'(rd_n)) &&
                   (!rd_line_start || (lines_stored != '0));
        any_elig = wr_elig || rd_elig;
        if (wr_elig && rd_elig) begin
            grant_dir = ~last_grant;
        end else begin
            grant_dir = wr_elig ? DIR_WR : DIR_RD;
        end
        sel_n    = (grant_dir == DIR_WR) ? wr_n : rd_n;
        sel_addr = (grant_dir == DIR_WR) ? wr_addr : rd_addr;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (latch && cfg_ok) begin
                    next_state = ST_ARB;
                end
            end
            ST_ARB: begin
                if (!enable) begin
                    next_state = ST_IDLE;
                end else if (any_elig) begin
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    next_state = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (cmd_done) begin
                    next_state = enable ? ST_ARB : ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign cmd_valid = (state == ST_ISSUE);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            enable_q      <= 1'b0;
            cfg_base      <= '0;
            cfg_stride    <= '0;
            cfg_beats     <= '0;
            cfg_vactive   <= '0;
            cfg_err       <= 1'b0;
            last_grant    <= DIR_RD;
            cmd_dir       <= DIR_WR;
            cmd_addr      <= '0;
            cmd_len       <= '0;
            lines_stored  <= '0;
            wr_frame_done <= 1'b0;
            rd_frame_done <= 1'b0;
        end else begin
            enable_q      <= enable;
            wr_frame_done <= 1'b0;
            rd_frame_done <= 1'b0;

            if (latch) begin
                cfg_base     <= frame_base;
                cfg_stride   <= line_stride;
                cfg_beats    <= line_beats;
                cfg_vactive  <= vactive;
                cfg_err      <= !cfg_ok;
                lines_stored <= '0;
            end

            if ((state == ST_ARB) && enable && any_elig) begin
                cmd_dir    <= grant_dir;
                last_grant <= grant_dir;
                cmd_addr   <= sel_addr;
                cmd_len    <= 8'(sel_n - 9'd1);
            end

            if (wr_adv) begin
                if (wr_line_end && (lines_stored < cfg_vactive)) begin
                    lines_stored <= lines_stored + 16'd1;
                end
                wr_frame_done <= wr_frame_wrap;
            end
            if (rd_adv) begin
                if (rd_line_end && (lines_stored != '0)) begin
                    lines_stored <= lines_stored - 16'd1;
                end
                rd_frame_done <= rd_frame_wrap;
            end
        end
    end

endmodule

// File: tb/tb_vdma_burst_scheduler.sv
// Self-checking bench for vdma_burst_scheduler. The reference model tracks
// each channel as a flat beat position within the frame and derives line,
// offset, burst length and address arithmetically.
module tb_vdma_burst_scheduler;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [31:0] frame_base, line_stride;
    logic [15:0] line_beats, vactive;
    logic [9:0]  wr_data_count, rd_space;
    logic        cmd_valid, cmd_ready, cmd_dir;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        cmd_done, busy;
    logic [15:0] lines_stored;
    logic        wr_frame_done, rd_frame_done, cfg_err;

    vdma_burst_scheduler #(
        .AXI_DSIZE (512),
        .ASIZE     (32),
        .BURST_LEN (32),
        .CSIZE     (10)
    ) dut (
        .clock         (clock),
        .rst_n         (rst_n),
        .enable        (enable),
        .frame_base    (frame_base),
        .line_stride   (line_stride),
        .line_beats    (line_beats),
        .vactive       (vactive),
        .wr_data_count (wr_data_count),
        .rd_space      (rd_space),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_dir       (cmd_dir),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .cmd_done      (cmd_done),
        .busy          (busy),
        .lines_stored  (lines_stored),
        .wr_frame_done (wr_frame_done),
        .rd_frame_done (rd_frame_done),
        .cfg_err       (cfg_err)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit [31:0] m_base, m_stride;
    int        m_lb, m_va;
    int        m_pos[2];
    int        m_stored;
    int        m_last;

    function automatic int m_n(input int pos);
        int rem;
        rem = m_lb - (pos % m_lb);
        return (rem > 32) ? 32 : rem;
    endfunction

    function automatic bit [31:0] m_addr(input int pos);
        return m_base + 32'(pos / m_lb) * m_stride + 32'(pos % m_lb) * 32'd64;
    endfunction

    function automatic bit m_elig(input int ch, input int cnt);
        bit start;
        start = ((m_pos[ch] % m_lb) == 0);
        if (cnt < m_n(m_pos[ch])) return 1'b0;
        if (!start) return 1'b1;
        return (ch == 0) ? (m_stored < m_va) : (m_stored > 0);
    endfunction

    function automatic int m_pick(input int wrc, input int rds);
        bit ew, er;
        ew = m_elig(0, wrc);
        er = m_elig(1, rds);
        if (ew && er) return (m_last == 1) ? 0 : 1;
        if (ew) return 0;
        if (er) return 1;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic no_cmd(input int cycles, input int wrc, input int rds, input string tag);
        wr_data_count = 10'(wrc);
        rd_space      = 10'(rds);
        for (int i = 0; i < cycles; i++) begin
            tick();
            check(tag, cmd_valid, 1'b0);
        end
    endtask

    task automatic restart(input bit [31:0] base, input bit [31:0] stride, input int lb, input int va);
        bit good;
        good          = (lb != 0) && (va != 0);
        enable        = 1'b0;
        wr_data_count = '0;
        rd_space      = '0;
        tick();
        tick();
        check("idle_busy", busy, 1'b0);
        frame_base  = base;
        line_stride = stride;
        line_beats  = 16'(lb);
        vactive     = 16'(va);
        enable      = 1'b1;
        tick();
        m_base   = base;
        m_stride = stride;
        m_lb     = lb;
        m_va     = va;
        m_pos[0] = 0;
        m_pos[1] = 0;
        m_stored = 0;
        check("start_busy", busy, good);
        check("start_cfg_err", cfg_err, !good);
        check("start_lines_stored", lines_stored, 0);
        // configuration edits while running must have no effect
        frame_base  = $urandom;
        line_stride = $urandom;
        line_beats  = 16'($urandom_range(1, 200));
        vactive     = 16'($urandom_range(1, 9));
    endtask

    // Called with the DUT in ARB. Drives FIFO levels, expects the grant the
    // model predicts one cycle later, handshakes and completes the burst.
    task automatic run_burst(input int wrc, input int rds, input int stall, input bit drop_en);
        int        exp_dir, n, waited, ch;
        bit [31:0] a;
        bit        wrap;
        exp_dir = m_pick(wrc, rds);
        if (exp_dir < 0) return;
        ch = exp_dir;
        wr_data_count = 10'(wrc);
        rd_space      = 10'(rds);
        n = m_n(m_pos[ch]);
        a = m_addr(m_pos[ch]);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!cmd_valid && waited < 20);
        check("cmd_valid_seen", cmd_valid, 1'b1);
        if (!cmd_valid) return;
        check("issue_latency", waited, 1);
        check("cmd_dir", cmd_dir, exp_dir);
        check("cmd_addr", cmd_addr, a);
        check("cmd_len", cmd_len, n - 1);
        check("busy_issue", busy, 1'b1);
        for (int i = 0; i < stall; i++) begin
            cmd_done = (i == 0);
            tick();
            cmd_done = 1'b0;
            check("stall_valid", cmd_valid, 1'b1);
            check("stall_dir", cmd_dir, exp_dir);
            check("stall_addr", cmd_addr, a);
            check("stall_len", cmd_len, n - 1);
        end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check("valid_drop", cmd_valid, 1'b0);
        check("busy_wait", busy, 1'b1);
        if (drop_en) enable = 1'b0;
        repeat ($urandom_range(0, 3)) begin
            tick();
            check("wait_no_valid", cmd_valid, 1'b0);
        end
        cmd_done = 1'b1;
        tick();
        cmd_done      = 1'b0;
        wr_data_count = '0;
        rd_space      = '0;
        m_pos[ch] += n;
        wrap = 1'b0;
        if ((m_pos[ch] % m_lb) == 0) begin
            m_stored += (ch == 0) ? 1 : -1;
            if (m_pos[ch] == m_lb * m_va) begin
                m_pos[ch] = 0;
                wrap = 1'b1;
            end
        end
        m_last = ch;
        check("lines_stored", lines_stored, m_stored);
        check("wr_frame_done", wr_frame_done, wrap && (ch == 0));
        check("rd_frame_done", rd_frame_done, wrap && (ch == 1));
        if (drop_en) check("busy_after_drop", busy, 1'b0);
        tick();
        check("wr_frame_done_clear", wr_frame_done, 1'b0);
        check("rd_frame_done_clear", rd_frame_done, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; cmd_ready = 1'b0; cmd_done = 1'b0;
        frame_base = '0; line_stride = '0; line_beats = '0; vactive = '0;
        wr_data_count = '0; rd_space = '0;
        m_last = 1;
        repeat (3) tick();
        check("rst_cmd_valid", cmd_valid, 1'b0);
        check("rst_cmd_dir", cmd_dir, 1'b0);
        check("rst_cmd_addr", cmd_addr, 32'h0);
        check("rst_cmd_len", cmd_len, 8'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_lines_stored", lines_stored, 16'h0);
        check("rst_cfg_err", cfg_err, 1'b0);
        check("rst_wr_frame_done", wr_frame_done, 1'b0);
        check("rst_rd_frame_done", rd_frame_done, 1'b0);
        rst_n = 1'b1;
        tick();

        // Write stream, read gating, buffer full and frame wrap
        restart(32'h1000_0000, 32'h0000_2000, 40, 2);
        no_cmd(5, 0, 64, "no_read_when_empty");
        run_burst(32, 0, 0, 1'b0);
        run_burst(8, 0, 0, 1'b0);
        run_burst(0, 64, 0, 1'b0);
        run_burst(32, 0, 0, 1'b0);
        run_burst(8, 0, 0, 1'b0);
        no_cmd(5, 64, 0, "write_blocked_full");
        run_burst(64, 64, 0, 1'b0);
        run_burst(64, 0, 0, 1'b0);
        check("third_line_addr_model", m_addr(0), 32'h1000_0000);

        // Both channels kept eligible: round-robin
        restart(32'h1000_0000, 32'h0000_2000, 40, 2);
        for (int i = 0; i < 8; i++) run_burst(64, 64, 0, 1'b0);

        // Backpressure, then enable dropped while a burst is outstanding
        restart(32'h1000_0000, 32'h0000_2000, 40, 2);
        run_burst(64, 0, 5, 1'b0);
        run_burst(64, 0, 0, 1'b1);
        no_cmd(4, 64, 64, "idle_after_disable");
        check("busy_idle_after_disable", busy, 1'b0);

        // Randomized traffic on the common configuration
        restart(32'h1000_0000, 32'h0000_2000, 40, 2);
        for (int it = 0; it < 30; it++) begin
            int wrc, rds, tries;
            tries = 0;
            do begin
                wrc = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 40)) : 64;
                rds = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 40)) : 64;
                tries++;
            end while (m_pick(wrc, rds) < 0 && tries < 20);
            if (m_pick(wrc, rds) < 0) begin
                wrc = 64;
                rds = 64;
            end
            run_burst(wrc, rds, $urandom_range(0, 3), 1'b0);
        end

        // Randomized geometry with addresses crossing the 32-bit wrap
        for (int cfg = 0; cfg < 3; cfg++) begin
            restart(32'hFFFF_E000, 32'h0000_1000, $urandom_range(1, 100), $urandom_range(1, 4));
            for (int it = 0; it < 15; it++) begin
                int wrc, rds, tries;
                tries = 0;
                do begin
                    wrc = int'($urandom_range(0, 64));
                    rds = int'($urandom_range(0, 64));
                    tries++;
                end while (m_pick(wrc, rds) < 0 && tries < 20);
                if (m_pick(wrc, rds) < 0) begin
                    wrc = 64;
                    rds = 64;
                end
                run_burst(wrc, rds, $urandom_range(0, 2), 1'b0);
            end
        end

        // Reset asserted while a command is being offered
        restart(32'h1000_0000, 32'h0000_2000, 40, 2);
        wr_data_count = 10'd64;
        for (int i = 0; i < 10 && !cmd_valid; i++) tick();
        check("pre_reset_valid", cmd_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cmd_valid", cmd_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_cmd_dir", cmd_dir, 1'b0);
        check("mid_rst_cmd_addr", cmd_addr, 32'h0);
        check("mid_rst_cmd_len", cmd_len, 8'h0);
        check("mid_rst_lines_stored", lines_stored, 16'h0);
        check("mid_rst_cfg_err", cfg_err, 1'b0);
        check("mid_rst_wr_frame_done", wr_frame_done, 1'b0);
        check("mid_rst_rd_frame_done", rd_frame_done, 1'b0);
        enable = 1'b0;
        wr_data_count = '0;
        tick();
        rst_n = 1'b1;
        m_last = 1;
        tick();

        // Invalid configurations
        restart(32'h1000_0000, 32'h0000_2000, 0, 2);
        no_cmd(6, 64, 64, "no_cmd_bad_beats");
        check("bad_beats_cfg_err", cfg_err, 1'b1);
        check("bad_beats_busy", busy, 1'b0);
        restart(32'h1000_0000, 32'h0000_2000, 40, 0);
        no_cmd(4, 64, 64, "no_cmd_bad_vactive");
        restart(32'h1000_0000, 32'h0000_2000, 40, 2);
        run_burst(64, 0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
